// File: rtl/enet_pll_supervisor.sv
// Ethernet PLL supervisor: sequences the PLL reset, qualifies lock stability, gates the
// downstream system reset, and retries a bounded number of times before latching failure.
module enet_pll_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 50,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 5000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic       pll_fail,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_lk;
    logic             w_can_retry;

    assign w_can_retry = (retry_cnt < RETRY_MAX);
    assign state_o     = r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_sync1     <= 1'b0;
            r_lk        <= 1'b0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            lock_lost   <= 1'b0;
            retry_cnt   <= 4'd0;
            pll_fail    <= 1'b0;
        end else begin
            // pll_locked is asynchronous to clk; only r_lk is used for decisions
            r_sync1   <= pll_locked;
            r_lk      <= r_sync1;
            lock_lost <= 1'b0;

            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    // lock takes priority over a timeout expiring on the same cycle
                    if (r_lk) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt   <= '0;
                        pll_rst <= 1'b1;
                        if (w_can_retry) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            r_state   <= S_PLL_RST;
                        end else begin
                            r_state  <= S_FAIL;
                            pll_fail <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_STABLE: begin
                    if (!r_lk) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        sys_reset_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (!r_lk) begin
                        sys_reset_n <= 1'b0;
                        lock_lost   <= 1'b1;
                        pll_rst     <= 1'b1;
                        r_cnt       <= '0;
                        if (w_can_retry) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            r_state   <= S_PLL_RST;
                        end else begin
                            r_state  <= S_FAIL;
                            pll_fail <= 1'b1;
                        end
                    end
                end

                S_FAIL: begin
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                    pll_fail    <= 1'b1;
                end

                default: begin
                    r_state     <= S_PLL_RST;
                    r_cnt       <= '0;
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enet_pll_supervisor.sv
// Bench for enet_pll_supervisor: scenario tasks with randomized lock timing, checked
// cycle by cycle against a phase/elapsed-time model of the supervisor's rules.
module tb_enet_pll_supervisor;

    localparam int unsigned PRST = 5;
    localparam int unsigned TOUT = 10;
    localparam int unsigned STAB = 30;
    localparam int unsigned MAXR = 3;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic       pll_fail;
    logic [2:0] state_o;

    int n_chk  = 0;
    int n_pass = 0;

    enet_pll_supervisor #(
        .PLL_RST_CYCLES     (PRST),
        .LOCK_TIMEOUT_CYCLES(TOUT),
        .LOCK_STABLE_CYCLES (STAB),
        .MAX_RETRIES        (MAXR),
        .CNT_W              (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_reset_n(sys_reset_n),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .pll_fail   (pll_fail),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0=reset PLL, 1=await lock, 2=qualify lock, 3=run, 4=failed
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_retries = 0;
    bit m_fail    = 1'b0;
    bit m_lost    = 1'b0;
    bit m_lk;
    bit m_hist[$];

    task automatic model_give_up_or_retry();
        m_elapsed = 0;
        if (m_retries < int'(MAXR)) begin
            m_retries = m_retries + 1;
            m_phase   = 0;
        end else begin
            m_phase = 4;
            m_fail  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        m_lk   = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
        m_lost = 1'b0;
        if (!reset_n) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0; m_fail = 1'b0;
            m_hist.delete();
        end else begin
            m_hist.push_back(pll_locked);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            if (m_phase == 0) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == int'(PRST)) begin m_phase = 1; m_elapsed = 0; end
            end else if (m_phase == 1) begin
                if (m_lk) begin
                    m_phase = 2; m_elapsed = 0;
                end else begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed == int'(TOUT)) model_give_up_or_retry();
                end
            end else if (m_phase == 2) begin
                if (!m_lk) begin
                    m_phase = 1; m_elapsed = 0;
                end else begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed == int'(STAB)) m_phase = 3;
                end
            end else if (m_phase == 3) begin
                if (!m_lk) begin
                    m_lost = 1'b1;
                    model_give_up_or_retry();
                end
            end
        end
    end

    logic [10:0] w_obs;
    logic [10:0] w_exp;
    assign w_obs = {pll_rst, sys_reset_n, lock_lost, retry_cnt, pll_fail, state_o};
    always_comb begin
        w_exp = {(m_phase == 0) || (m_phase == 4), (m_phase == 3), m_lost,
                 4'(m_retries), m_fail, 3'(m_phase)};
    end

    localparam logic [10:0] RST_VEC = 11'b100_0000_0000;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pll_locked = 1'b0;
        tick(); tick(); tick();
        n_chk++;
        if (w_obs !== RST_VEC) $display("FAIL reset_vec: got %b want %b", w_obs, RST_VEC);
        else n_pass++;
        n_chk++;
        if (w_obs !== w_exp) $display("FAIL reset_model: got %b want %b", w_obs, w_exp);
        else n_pass++;
    endtask

    task automatic test_clean_start();
        int d, k, rst_len, rise_t;
        bit seen_wait;
        d = int'($urandom_range(0, 6)); k = 0; rise_t = -1; seen_wait = 1'b0;
        rst_len = (pll_rst === 1'b1) ? 1 : 0;
        reset_n = 1'b1;
        for (int t = 1; t <= 200 && rise_t < 0; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL clean_start t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (pll_rst === 1'b1) rst_len++;
            if (sys_reset_n === 1'b1) rise_t = t;
            if (state_o === 3'd1 && !seen_wait) begin seen_wait = 1'b1; k = 0; end
            if (seen_wait) begin
                if (k == d) pll_locked = 1'b1;
                k++;
            end
        end
        n_chk++;
        if (rst_len != int'(PRST)) $display("FAIL clean_rst_len: got %0d want %0d", rst_len, PRST);
        else n_pass++;
        n_chk++;
        if (rise_t != int'(PRST) + d + 3 + int'(STAB))
            $display("FAIL clean_rise_time: got %0d want %0d", rise_t, int'(PRST) + d + 3 + int'(STAB));
        else n_pass++;
        n_chk++;
        if (retry_cnt !== 4'd0 || pll_fail !== 1'b0)
            $display("FAIL clean_status: got retry=%0d fail=%b want 0/0", retry_cnt, pll_fail);
        else n_pass++;
    endtask

    task automatic test_lock_loss_run();
        int lost_n, drop_t, rst_len;
        bit reached;
        lost_n = 0; drop_t = -1; rst_len = 0; reached = 1'b0;
        pll_locked = 1'b0;
        for (int t = 1; t <= 150 && !reached; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL lock_loss t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (lock_lost === 1'b1) lost_n++;
            if (pll_rst === 1'b1) begin rst_len++; pll_locked = 1'b1; end
            if (sys_reset_n === 1'b0 && drop_t < 0) drop_t = t;
            if (drop_t > 0 && sys_reset_n === 1'b1) reached = 1'b1;
        end
        n_chk++;
        if (drop_t != 3) $display("FAIL loss_sys_drop: got tick %0d want 3", drop_t);
        else n_pass++;
        n_chk++;
        if (lost_n != 1) $display("FAIL loss_pulse_width: got %0d want 1", lost_n);
        else n_pass++;
        n_chk++;
        if (rst_len != int'(PRST)) $display("FAIL loss_rst_len: got %0d want %0d", rst_len, PRST);
        else n_pass++;
        n_chk++;
        if (retry_cnt !== 4'd1 || !reached)
            $display("FAIL loss_retry: got retry=%0d relocked=%b want 1/1", retry_cnt, reached);
        else n_pass++;
    endtask

    task automatic test_reset_in_run();
        n_chk++;
        if (state_o !== 3'd3) $display("FAIL rst_run_pre: got state %0d want 3", state_o);
        else n_pass++;
        reset_n = 1'b0;
        tick();
        n_chk++;
        if (w_obs !== RST_VEC) $display("FAIL rst_in_run: got %b want %b", w_obs, RST_VEC);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_chatter();
        int p, g, k, t_rest, rise_t;
        bit in_st, saw_wait;
        p = int'($urandom_range(5, 20)); g = int'($urandom_range(1, 4));
        k = 0; t_rest = -1; rise_t = -1; in_st = 1'b0; saw_wait = 1'b0;
        pll_locked = 1'b1;
        for (int t = 1; t <= 300 && rise_t < 0; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL chatter t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (sys_reset_n === 1'b1) rise_t = t;
            if (!in_st && state_o === 3'd2) begin in_st = 1'b1; k = 0; end
            if (in_st) begin
                if (k > p && state_o === 3'd1) saw_wait = 1'b1;
                if (k == p) pll_locked = 1'b0;
                if (k == p + g) begin pll_locked = 1'b1; t_rest = t; end
                k++;
            end
        end
        n_chk++;
        if (!saw_wait) $display("FAIL chatter_wait: got no return to state 1, want return");
        else n_pass++;
        n_chk++;
        if (rise_t - t_rest != 3 + int'(STAB))
            $display("FAIL chatter_restart: got %0d want %0d", rise_t - t_rest, 3 + int'(STAB));
        else n_pass++;
        n_chk++;
        if (retry_cnt !== 4'd0) $display("FAIL chatter_retry: got %0d want 0", retry_cnt);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int k;
        bit seen, done;
        k = 0; seen = 1'b0; done = 1'b0;
        reset_n = 1'b0; pll_locked = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        for (int t = 1; t <= 100 && !done; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL simul t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (!seen && state_o === 3'd1) begin seen = 1'b1; k = 0; end
            else if (seen) k++;
            if (seen) begin
                if (k == 7) pll_locked = 1'b1;
                if (k == 9) begin
                    n_chk++;
                    if (state_o !== 3'd1) $display("FAIL simul_pre_edge: got %0d want 1", state_o);
                    else n_pass++;
                end
                if (k == 10) begin
                    n_chk++;
                    if (state_o !== 3'd2 || retry_cnt !== 4'd0)
                        $display("FAIL simul_lock_wins: got state=%0d retry=%0d want 2/0", state_o, retry_cnt);
                    else n_pass++;
                end
                if (k == 7 + int'(STAB)) pll_locked = 1'b0;
                if (k == 9 + int'(STAB)) begin
                    n_chk++;
                    if (state_o !== 3'd2) $display("FAIL simul_stable_hold: got %0d want 2", state_o);
                    else n_pass++;
                end
                if (k == 10 + int'(STAB)) begin
                    n_chk++;
                    if (state_o !== 3'd1 || sys_reset_n !== 1'b0)
                        $display("FAIL simul_fall_wins: got state=%0d sys=%b want 1/0", state_o, sys_reset_n);
                    else n_pass++;
                    done = 1'b1;
                end
            end
        end
        n_chk++;
        if (!done) $display("FAIL simul_timeout: got no completion want completion");
        else n_pass++;
    endtask

    task automatic test_timeout_fail();
        int rises, seq[$];
        logic prev_rst;
        logic [3:0] prev_retry;
        bit failed;
        rises = 0; failed = 1'b0; prev_rst = pll_rst; prev_retry = retry_cnt;
        pll_locked = 1'b0;
        for (int t = 1; t <= 300 && !failed; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL timeout t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (pll_rst === 1'b1 && prev_rst === 1'b0) rises++;
            if (retry_cnt !== prev_retry) seq.push_back(int'(retry_cnt));
            prev_rst = pll_rst; prev_retry = retry_cnt;
            if (state_o === 3'd4) failed = 1'b1;
        end
        n_chk++;
        if (seq.size() != 3 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3)
            $display("FAIL timeout_retry_seq: got %0d steps want 1,2,3", seq.size());
        else n_pass++;
        n_chk++;
        if (rises != 4) $display("FAIL timeout_rst_rises: got %0d want 4", rises);
        else n_pass++;
        n_chk++;
        if (w_obs !== 11'b100_0011_1100) $display("FAIL fail_state: got %b want %b", w_obs, 11'b100_0011_1100);
        else n_pass++;
        pll_locked = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL fail_sticky t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
        end
        n_chk++;
        if (state_o !== 3'd4 || pll_fail !== 1'b1 || pll_rst !== 1'b1)
            $display("FAIL fail_ignores_lock: got state=%0d fail=%b rst=%b want 4/1/1", state_o, pll_fail, pll_rst);
        else n_pass++;
    endtask

    task automatic test_reset_in_fail();
        bit reached;
        reached = 1'b0;
        reset_n = 1'b0;
        tick();
        n_chk++;
        if (w_obs !== RST_VEC) $display("FAIL rst_in_fail: got %b want %b", w_obs, RST_VEC);
        else n_pass++;
        reset_n = 1'b1;
        for (int t = 1; t <= 100 && !reached; t++) begin
            tick();
            n_chk++;
            if (w_obs !== w_exp) $display("FAIL rerun t=%0d: got %b want %b", t, w_obs, w_exp);
            else n_pass++;
            if (sys_reset_n === 1'b1) reached = 1'b1;
        end
        n_chk++;
        if (!reached || retry_cnt !== 4'd0 || pll_fail !== 1'b0)
            $display("FAIL rerun_after_fail: got run=%b retry=%0d fail=%b want 1/0/0", reached, retry_cnt, pll_fail);
        else n_pass++;
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_clean_start();
        test_lock_loss_run();
        test_reset_in_run();
        test_chatter();
        test_simultaneous();
        test_timeout_fail();
        test_reset_in_fail();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/enet_pll_supervisor.md
Name: enet_pll_supervisor

Overview:
Controls the Ethernet clock PLL and monitors it. The block drives the PLL reset and watches the PLL lock indication. It releases a downstream system reset only after lock has stayed stable for a set time. On lock timeout or lock loss it re-resets the PLL, with a bounded retry count; when retries run out it latches a failure flag. It runs on the 50 MHz board reference clock and sits between the board reset and the Ethernet MAC/TSE clock-domain logic.

Parameters:
PLL_RST_CYCLES, 50, pll_rst assertion length in clk cycles (1 us @ 50 MHz); minimum 1
LOCK_TIMEOUT_CYCLES, 50000, maximum wait for synchronized lock after pll_rst deasserts (1 ms)
LOCK_STABLE_CYCLES, 5000, consecutive cycles lock must stay high before sys_reset_n releases (100 us)
MAX_RETRIES, 3, PLL reset retries allowed after the first attempt before FAIL; range 0..15
CNT_W, 20, width of the shared cycle counter; must hold max(all cycle parameters)

Ports:
clk  input  1  50 MHz reference clock, same net as PLL refclk
reset_n  input  1  synchronous active-low reset
pll_locked  input  1  PLL lock output; asynchronous to clk
pll_rst  output  1  active-high PLL reset
sys_reset_n  output  1  active-low reset for logic clocked by PLL outputs; changes only on clk edges
lock_lost  output  1  one-cycle pulse when lock drops while in RUN
retry_cnt  output  4  number of PLL reset retries issued since reset_n
pll_fail  output  1  sticky; high once the retry budget is exhausted
state_o  output  3  current state encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

Behaviour:
- pll_locked passes through a 2-flop synchronizer to give lk. All decisions below use lk, which adds 2 cycles of latency.
- While reset_n=0 at a clk edge, the block enters PLL_RST with counter=0, pll_rst=1, sys_reset_n=0, lock_lost=0, retry_cnt=0, pll_fail=0, state_o=0, and synchronizer flops=0. A reset_n assertion in any state, mid-operation, has the same effect on the next edge.
- PLL_RST: pll_rst=1 and the counter increments. When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK with counter=0. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0 and the counter increments.
  - lk=1: go to STABLE, counter=0.
  - else if counter==LOCK_TIMEOUT_CYCLES-1: retry (see below).
- STABLE: the counter increments while lk=1.
  - lk=0: go back to WAIT_LOCK, counter=0. The timeout restarts and retry_cnt is not incremented.
  - counter==LOCK_STABLE_CYCLES-1 with lk=1: go to RUN. sys_reset_n rises on the same edge.
- RUN: sys_reset_n=1, counter idle.
  - lk=0: sys_reset_n goes to 0 on the same edge, lock_lost pulses high for exactly 1 cycle, then retry.
  - A lk glitch shorter than one clk cycle that the synchronizer never captures is ignored.
- Retry:
  - If retry_cnt < MAX_RETRIES: retry_cnt += 1, go to PLL_RST, counter=0.
  - Otherwise: go to FAIL.
  - retry_cnt saturates at MAX_RETRIES and never wraps.
- FAIL: pll_fail=1 (sticky), pll_rst=1 (PLL held in reset), sys_reset_n=0. Only reset_n exits FAIL. lk is ignored.
- sys_reset_n=1 only in RUN; pll_rst=1 only in PLL_RST and FAIL. All outputs are registered.
- Simultaneous events:
  - lk rising on the same cycle the WAIT_LOCK timeout expires: lock wins, go to STABLE.
  - lk falling on the cycle STABLE would complete: the fall wins, go to WAIT_LOCK.
- Lock-loss retries count against the same budget as timeouts.

Test Plan:
- Clean start (defaults), with pll_locked rising 300 cycles after pll_rst falls:
  - pll_rst is high for cycles 0..49.
  - sys_reset_n rises 50+300+2+5000 cycles after reset_n deassertion (±1 for the synchronizer phase).
  - retry_cnt=0, pll_fail=0.
- pll_locked never asserts, MAX_RETRIES=3:
  - Four pll_rst pulses of 50 cycles each, spaced 50000 cycles apart.
  - retry_cnt steps 1,2,3, then state_o=4, pll_fail=1, pll_rst held at 1.
  - A subsequent pll_locked=1 has no effect.
- Lock drops while in RUN:
  - sys_reset_n falls on the edge after lk falls.
  - lock_lost is high for exactly 1 cycle.
  - retry_cnt increments by 1 and a new 50-cycle pll_rst pulse follows.
- Lock chatter during STABLE (drop at cycle 4000, return 10 cycles later):
  - State returns to WAIT_LOCK and then STABLE.
  - The stability count restarts, so sys_reset_n is delayed by a further full 5000 cycles.
  - retry_cnt is unchanged.
- reset_n asserted for 1 cycle in RUN and in FAIL:
  - Next edge: pll_rst=1, sys_reset_n=0, pll_fail=0, retry_cnt=0, state_o=0.
  - The full sequence then repeats.
- Simultaneous events with LOCK_TIMEOUT_CYCLES=10:
  - lk rising on WAIT_LOCK counter==9 goes to STABLE, with no retry.
  - lk falling on STABLE's final cycle goes to WAIT_LOCK, and sys_reset_n stays 0.
